link_buffer_mem: RTL
====================

LINK_BUFFER_MEM -- requirements
Module: link_buffer_mem

Interface
REQ-001 Parameter DATA_WIDTH, default 40, width of one link data word.
REQ-002 Parameter ADDR_WIDTH, default 4, log2 of buffer depth (DEPTH = 2**ADDR_WIDTH = 16).
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Ports link_data0..link_data3  input  DATA_WIDTH each  candidate link words.
REQ-006 Port link_num  input  2  selects which link_data word is written.
REQ-007 Port wr_en  input  1  write request from the input router.
REQ-008 Port full  output  1  buffer full flag, feeds the mux controller's in_full.
REQ-009 Port rd_en  input  1  read request from the downstream consumer.
REQ-010 Port rd_data  output  DATA_WIDTH  registered read word.
REQ-011 Port rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-012 Port empty  output  1  buffer empty flag.
REQ-013 Port overflow  output  1  sticky flag, write attempted while full.

Function
REQ-014 Storage SHALL be a DEPTH x DATA_WIDTH circular array with write and read pointers of ADDR_WIDTH+1 bits each; the MSB is the wrap bit.
REQ-015 Accepted write (wr_en=1 and full=0) SHALL store link_data[link_num] at wr_ptr[ADDR_WIDTH-1:0] and increment wr_ptr, wrapping from 2*DEPTH-1 to 0.
REQ-016 Accepted read (rd_en=1 and empty=0) SHALL load rd_data from rd_ptr[ADDR_WIDTH-1:0] on the same edge, assert rd_valid for exactly the next cycle, and increment rd_ptr with the same wrap rule; read latency is 1 cycle.
REQ-017 rd_data SHALL hold its last value when no read is accepted; rd_valid SHALL be 0 in that cycle.
REQ-018 full SHALL be 1 when the address bits of wr_ptr and rd_ptr are equal and the wrap bits differ; empty SHALL be 1 when the pointers are fully equal; both SHALL be decoded from registered pointers only.
REQ-019 Acceptance SHALL be judged on flag values before the edge: when full, a simultaneous read is accepted and the write is rejected; when empty, a simultaneous write is accepted and the read is rejected (no bypass).
REQ-020 When neither full nor empty, simultaneous read and write SHALL both be accepted and occupancy SHALL be unchanged.
REQ-021 wr_en=1 while full=1 SHALL set overflow and SHALL leave array and pointers unchanged; overflow SHALL remain set until reset.
REQ-022 rd_en=1 while empty=1 SHALL be ignored, with no flag and no pointer change.
REQ-023 link_num SHALL be sampled only in cycles where a write is accepted.

Reset
REQ-024 On rst=1 at posedge clk: wr_ptr=0, rd_ptr=0, rd_data=0, rd_valid=0, overflow=0, so empty=1 and full=0 from the following cycle.
REQ-025 rst SHALL take priority over simultaneous wr_en and rd_en; array contents need not be cleared, and mid-operation reset SHALL discard all stored words.

Configuration
REQ-026 Macro LINK_BUFFER_COUNT_EN defined: an output port fill_count (ADDR_WIDTH+1 bits) SHALL equal wr_ptr minus rd_ptr, modulo 2**(ADDR_WIDTH+1), reading 0..DEPTH and resetting to 0.
REQ-027 Macro LINK_BUFFER_COUNT_EN undefined: the fill_count port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 After reset, write link_data2=40'hAA_0000_0002 with link_num=2; next cycle, rd_en=1 -> rd_data=40'hAA00000002 and rd_valid=1 one cycle later, then empty=1.
REQ-029 16 consecutive writes with rd_en=0 -> full=1 after the 16th; a 17th write -> overflow=1, and reading 16 words returns the first 16 values in order.
REQ-030 While full, wr_en=1 and rd_en=1 together -> read accepted, write dropped, full=0 next cycle, fill_count=15 (with LINK_BUFFER_COUNT_EN).
REQ-031 While empty, wr_en=1 and rd_en=1 together -> rd_valid=0, empty=0 next cycle, and a following read returns the written word.
REQ-032 Run 40 write/read pairs at occupancy 3 so both pointers wrap -> data order preserved, full and empty never asserted, fill_count constant at 3.
REQ-033 Assert rst with 5 words stored and wr_en=1 -> next cycle empty=1, full=0, overflow=0, rd_valid=0, and the write is not stored.

Source files
------------

// File: rtl/link_buffer_mem.sv
// Circular link-word buffer: selects one of four link words per write, with a 1-cycle registered read.
// Optional fill_count output is built when LINK_BUFFER_COUNT_EN is defined.
module link_buffer_mem #(
  parameter int DATA_WIDTH = 40,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] link_data0,
  input  logic [DATA_WIDTH-1:0] link_data1,
  input  logic [DATA_WIDTH-1:0] link_data2,
  input  logic [DATA_WIDTH-1:0] link_data3,
  input  logic [1:0]            link_num,
  input  logic                  wr_en,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
`ifdef LINK_BUFFER_COUNT_EN
  output logic [ADDR_WIDTH:0]   fill_count,
`endif
  output logic                  overflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_overflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic [DATA_WIDTH-1:0] w_wr_word;

  // Flags come only from registered pointers; the MSB is the wrap bit.
  assign w_full  = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                   (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign w_wr_accept = wr_en && !w_full;
  assign w_rd_accept = rd_en && !w_empty;

  always_comb begin
    w_wr_word = link_data0;
    case (link_num)
      2'd0: w_wr_word = link_data0;
      2'd1: w_wr_word = link_data1;
      2'd2: w_wr_word = link_data2;
      2'd3: w_wr_word = link_data3;
      default: w_wr_word = link_data0;
    endcase
  end

  // Array has no reset so it maps onto block RAM; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_accept) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= w_wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_accept;
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_accept) begin
        r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign overflow = r_overflow;

`ifdef LINK_BUFFER_COUNT_EN
  assign fill_count = r_wr_ptr - r_rd_ptr;
`endif

endmodule
